// File: rtl/pulse_gen_pkg.sv
// rtl/pulse_gen_pkg.sv - shared constants and bus slicing helper for multi_channel_pulse_gen
package pulse_gen_pkg;

  localparam int DEFAULT_CNT_W = 16;
  localparam int MAX_NUM_CH    = 16;

  // Low bit index of channel ch inside a packed NUM_CH*w bus.
  function automatic int slice_lo(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/pulse_gen_ch.sv
// rtl/pulse_gen_ch.sv - one pulse channel: counter, active/pending settings, registered outputs
module pulse_gen_ch
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_start,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] high,
  input  logic             load,
  output logic             r,
  output logic             wrap,
  output logic             busy
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] act_p, act_h;
  logic [CNT_W-1:0] pend_p, pend_h;
  logic             pend_v;
  logic             en_q;

  logic             restart;
  logic             apply;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] act_p_nxt, act_h_nxt;

  // A restart is a rising enable, a counter reaching its period, or a forced phase-align.
  always_comb begin
    restart   = en && (!en_q || (cnt == act_p) || sync_start);
    apply     = restart && pend_v;
    act_p_nxt = apply ? pend_p : act_p;
    act_h_nxt = apply ? pend_h : act_h;
    cnt_nxt   = '0;
    if (en && !restart) cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      act_p  <= '0;
      act_h  <= '0;
      pend_p <= '0;
      pend_h <= '0;
      pend_v <= 1'b0;
      en_q   <= 1'b0;
      r      <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      en_q  <= en;
      cnt   <= cnt_nxt;
      act_p <= act_p_nxt;
      act_h <= act_h_nxt;
      wrap  <= restart;
      r     <= en && (cnt_nxt < act_h_nxt);
      // A load on a boundary edge lands after the old pending value was consumed.
      if (load) begin
        pend_p <= period;
        pend_h <= high;
        pend_v <= 1'b1;
      end else if (apply) begin
        pend_v <= 1'b0;
      end
    end
  end

  assign busy = pend_v;

endmodule

// File: rtl/multi_channel_pulse_gen.sv
// rtl/multi_channel_pulse_gen.sv - NUM_CH independent pulse generators; PULSE_GEN_SYNC_START_EN adds sync_start
module multi_channel_pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH*CNT_W-1:0] period,
  input  logic [NUM_CH*CNT_W-1:0] high,
  input  logic [NUM_CH-1:0]       load,
`ifdef PULSE_GEN_SYNC_START_EN
  input  logic                    sync_start,
`endif
  output logic [NUM_CH-1:0]       r,
  output logic [NUM_CH-1:0]       wrap,
  output logic [NUM_CH-1:0]       busy
);

  logic sync_all;

`ifdef PULSE_GEN_SYNC_START_EN
  assign sync_all = sync_start;
`else
  assign sync_all = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam int LO = slice_lo(i, CNT_W);

    pulse_gen_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .en         (en[i]),
      .sync_start (sync_all),
      .period     (period[LO +: CNT_W]),
      .high       (high[LO +: CNT_W]),
      .load       (load[i]),
      .r          (r[i]),
      .wrap       (wrap[i]),
      .busy       (busy[i])
    );
  end

endmodule
